unpacked_array_event_counter: RTL
=================================

Name: unpacked_array_event_counter

Overview:
Per-lane rising-edge event counter placed directly downstream of the M-lane flag register stage. It consumes that stage's unpacked 1-bit-per-lane output array and keeps one saturating counter per lane. Counter values are published on an unpacked output array through a four-phase snapshot handshake. Unpacked ports use the size form of declaration ([M]), so TMRG unpacked-port handling is exercised on a block with real state.

Parameters:
M, 2, number of lanes (M >= 1)
CW, 8, counter width per lane in bits (CW >= 2)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
d  input  logic d [M] (unpacked, 1 bit per lane)  lane flags from upstream register stage, synchronous to clock
clear  input  1  synchronous clear of all counters and overflow flags
snap_req  input  1  snapshot request, four-phase level handshake
snap_ack  output  1  snapshot acknowledge
count  output  logic [CW-1:0] count [M] (unpacked)  snapshotted counter values
ovf  output  logic ovf [M] (unpacked)  snapshotted sticky saturation flags
any_event  output  1  registered; 1 if any lane detected a rising edge in the previous cycle

Behaviour:
- Reset (reset=1 at a clock edge): d_q[i]=0, cnt[i]=0, sat[i]=0, count[i]=0, ovf[i]=0, snap_ack=0, any_event=0, FSM=IDLE. Reset overrides all other inputs.
- Edge detect: d_q[i] is a one-cycle delayed copy of d[i]. Combinational edge[i] = d[i] & ~d_q[i].
  - A lane high in the first cycle after reset counts as one edge.
- Counter, per lane, at each edge:
  - clear=1: cnt[i]=0 and sat[i]=0. Clear wins over a simultaneous edge; that edge is lost.
  - else if edge[i] and cnt[i] < 2^CW-1: cnt[i]+1.
  - else if edge[i] and cnt[i] == 2^CW-1: cnt[i] holds and sat[i] becomes 1.
  - No wrap-around. sat[i] is sticky until clear or reset.
- any_event <= OR over edge[i], independent of clear.
- Snapshot FSM, states IDLE and ACK:
  - IDLE, snap_req=1 at an edge: count[i] <= cnt[i], ovf[i] <= sat[i], go to ACK.
  - In that same edge, capture takes pre-clear and pre-increment values, because the register values at the edge are used.
  - ACK: snap_ack=1 (a registered state decode). count and ovf hold.
  - ACK, snap_req=0 at an edge: go to IDLE; snap_ack=0 the following cycle.
  - Latency: snap_req rises before edge n, so count, ovf and snap_ack are valid in the cycle after edge n. Next capture is possible no earlier than edge n+2.
  - snap_req held high in ACK causes no recapture. Outputs are stable while snap_ack=1.
- Counters keep running during ACK; only the published arrays are frozen.
- Reset mid-handshake: FSM returns to IDLE. If snap_req is still 1 when reset drops, a new capture occurs at the next edge.
- The lane-to-index mapping is identity: d[i] drives cnt[i], count[i] and ovf[i] for i = 0..M-1.

Test Plan:
- Reset, M=2, CW=8: assert reset for 2 cycles with d={1,1} → all outputs 0. Release with d held {1,1}, then snapshot → count={1,1}, ovf={0,0}.
- Pulses: lane 0 toggles 0/1 five times, lane 1 static 0, then snapshot → count={5,0}, ovf={0,0}. any_event pulses exactly 5 times, each one cycle after the rising edge.
- Saturation, CW=2: lane 0 gets 5 rising edges → count[0]=3, ovf[0]=1. After clear and another snapshot → count[0]=0, ovf[0]=0.
- Clear/edge collision: clear=1 in the same cycle as a lane-1 rising edge, with cnt[1]=4 before it → next snapshot shows count[1]=0.
- Snapshot plus clear in the same cycle, with cnt={7,2} → count={7,2} and snap_ack=1 next cycle. A later snapshot shows {0,0} if there were no further edges.
- Handshake: hold snap_req=1 for 6 cycles while lane 0 keeps pulsing → snap_ack stays 1 and count stays frozen. After snap_req drops, snap_ack drops one cycle later. A new request captures the updated value.

Source files
------------

// File: rtl/unpacked_array_event_counter.sv
// Per-lane rising-edge event counter with saturating counts,
// published on unpacked arrays through a four-phase snapshot handshake.
module unpacked_array_event_counter #(
    parameter int M  = 2,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          d [M],
    input  logic          clear,
    input  logic          snap_req,
    output logic          snap_ack,
    output logic [CW-1:0] count [M],
    output logic          ovf [M],
    output logic          any_event
);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    state_t        state;
    state_t        state_nx;
    logic          capture;
    logic          d_q  [M];
    logic [CW-1:0] cnt  [M];
    logic          sat  [M];
    logic          rise [M];
    logic          any_rise;

    always_comb begin
        any_rise = 1'b0;
        for (int i = 0; i < M; i++) begin
            rise[i]  = d[i] & ~d_q[i];
            any_rise = any_rise | rise[i];
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (snap_req) begin
                    capture  = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: begin
                if (!snap_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign snap_ack = (state == ACK);

    always_ff @(posedge clock) begin
        if (reset) begin
            any_event <= 1'b0;
        end else begin
            any_event <= any_rise;
        end
    end

    // Capture reads the register values at the edge, so a same-cycle
    // clear or increment is not visible in the published snapshot.
    always_ff @(posedge clock) begin
        for (int i = 0; i < M; i++) begin
            if (reset) begin
                d_q[i]   <= 1'b0;
                cnt[i]   <= '0;
                sat[i]   <= 1'b0;
                count[i] <= '0;
                ovf[i]   <= 1'b0;
            end else begin
                d_q[i] <= d[i];
                if (clear) begin
                    cnt[i] <= '0;
                    sat[i] <= 1'b0;
                end else if (rise[i]) begin
                    if (cnt[i] != CMAX) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end else begin
                        sat[i] <= 1'b1;
                    end
                end
                if (capture) begin
                    count[i] <= cnt[i];
                    ovf[i]   <= sat[i];
                end
            end
        end
    end

endmodule
